// File: rtl/smol_mem_arbiter.sv
// Fetch/data arbiter in front of the single SmolCore memory: IDLE -> ISSUE -> (RESP) with registered pins.
// Define SMOL_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to the data port.
module smol_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  // Handshake: a port raises req and holds it (with stable command fields) until it
  // sees its gnt; req still high in the cycle after gnt is a fresh request.
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   owner;   // 1 = data port owns the current access
  logic   pick_d;

`ifdef SMOL_ARB_ROUND_ROBIN_EN
  logic last_owner;  // 1 = data port was granted last

  always_comb begin
    pick_d = d_req;
    if (if_req && d_req) pick_d = ~last_owner;
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      memAddr   <= 32'd0;
      writeData <= 32'd0;
`ifdef SMOL_ARB_ROUND_ROBIN_EN
      last_owner <= 1'b1;
`endif
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      case (state)
        ISSUE: begin
          // memRead/memWrite still hold the direction of the access being issued
          state     <= memWrite ? IDLE : RESP;
          if_rvalid <= memRead & ~owner;
          d_rvalid  <= memRead & owner;
        end
        default: begin
          if (if_req || d_req) begin
            state    <= ISSUE;
            owner    <= pick_d;
            if_gnt   <= ~pick_d;
            d_gnt    <= pick_d;
            memRead  <= ~(pick_d & d_we);
            memWrite <= pick_d & d_we;
            memAddr  <= pick_d ? d_addr : if_addr;
            if (pick_d) writeData <= d_wdata;
`ifdef SMOL_ARB_ROUND_ROBIN_EN
            last_owner <= pick_d;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign if_rdata = (state == RESP && !owner) ? readData : 32'd0;
  assign d_rdata  = (state == RESP &&  owner) ? readData : 32'd0;

endmodule
